pong_game_sequencer: RTL and testbench
======================================

// Module: pong_game_sequencer
// PURPOSE
//  Game-level controller for the single-player tennis video path. Sequences the ball/raket
//  datapath through attract, serve countdown, play, miss and game-over phases. Gates ball
//  motion, commands ball reload/serve direction, counts raket hits (BCD score), lives and
//  speed level. Sits beside VGAGenerator; all I/O is synchronous to pixelClock.
// PARAMETERS
//  SERVE_FRAMES   60  frames of countdown in SERVE before ball is released
//  MISS_FRAMES    90  frames of border flash in MISS before next serve / game over
//  LIVES_INIT     3   lives loaded on game start (1..7)
//  HITS_PER_LEVEL 10  raket hits per speed-level increment
// PORTS
//  reset       in   1   asynchronous, active-high
//  pixelClock  in   1   clock
//  frameTick   in   1   1-cycle pulse per frame (e.g. vSync falling edge), pixelClock domain
//  startBtn    in   1   raw pushbutton, active-high, asynchronous to pixelClock
//  ballMiss    in   1   1-cycle pulse: ball passed raket column (reached right border)
//  raketHit    in   1   1-cycle pulse: ball reflected by raket
//  ballRun     out  1   1 = ball position may update; 0 = ball frozen
//  ballLoad    out  1   1-cycle pulse: reload ball to serve position (screen centre)
//  serveDir    out  1   dy for the coming serve; toggles on every ballLoad
//  speedLevel  out  2   0..3, ball step selector for datapath
//  scoreBcd    out  16  4 BCD digits of raket hits, [15:12] = thousands
//  lives       out  3   remaining lives
//  flash       out  1   border highlight request (MISS blink, GAME_OVER steady)
//  gameState   out  3   current FSM state encoding, for debug/overlay
// BEHAVIOUR
//  Reset (any time, incl. mid-game): state=IDLE, ballRun=0, ballLoad=0, serveDir=0,
//   speedLevel=0, scoreBcd=0, lives=LIVES_INIT, flash=0, counters=0. Outputs registered.
//  startBtn: 2-FF synchronizer + rising-edge detect -> startPulse (3 cycles latency).
//  States: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4; others -> IDLE next cycle.
//   IDLE : ballRun=0. startPulse -> clear score/level, lives=LIVES_INIT, ballLoad, ->SERVE.
//   SERVE: ballRun=0; frameCnt counts frameTick; at SERVE_FRAMES -> PLAY, frameCnt=0.
//   PLAY : ballRun=1. raketHit -> score+1, hitCnt+1; hitCnt==HITS_PER_LEVEL-1 on hit ->
//          hitCnt=0, speedLevel+1 (saturate 3). ballMiss -> lives-1, ballRun=0, ->MISS.
//   MISS : flash = frameCnt[3] (8-frame blink); at MISS_FRAMES: lives==0 -> OVER,
//          else ballLoad pulse, ->SERVE. speedLevel drops by 1 (floor 0) on entry.
//   OVER : flash=1, ballRun=0; score/level held; startPulse -> as IDLE start.
//  Simultaneous raketHit+ballMiss in PLAY: miss wins, no score. Hit/miss outside PLAY ignored.
//  startPulse in SERVE/PLAY/MISS ignored. frameTick+event same cycle: both take effect.
//  Score: BCD ripple, saturates at 9999 (no wrap). ballLoad always exactly 1 cycle.
//  Register updates on the pixelClock edge of the event; outputs valid the next cycle.
// STRUCTURE
//  pong_defs.vh : state encodings, ball speed table width, LIVES width.
//  Sub-module bcd_counter4 (inc, clr, sat at 9999, 16-bit out) instantiated for scoreBcd.
//  FSM + frame/hit counters + synchronizer stay in this module.
// TESTING
//  T1 reset mid-PLAY with score=0x0042 -> next cycle IDLE, score 0, lives 3, ballRun 0.
//  T2 start edge, 60 frameTicks -> ballLoad once at start, ballRun rises after 60th tick.
//  T3 PLAY, 3 misses each followed by 90 ticks -> lives 3->0, ends OVER, flash=1 steady.
//  T4 25 raketHits in PLAY -> scoreBcd=0x0025, speedLevel=2; 10 more -> level 3 held.
//  T5 raketHit+ballMiss same cycle -> score unchanged, lives-1, state MISS.
//  T6 preload score 0x9998, 3 hits -> 0x9999 held; startBtn bounce in PLAY -> no effect.

Source files
------------

// File: rtl/pong_game_sequencer_pkg.sv
// ============================================================================
// Module      : pong_game_sequencer_pkg
// Description : Shared state encodings and speed-level helpers for the
//               pong game sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } gameState_t;

    localparam int         C_LIVES_W   = 3;
    localparam int         C_LEVEL_W   = 2;
    localparam logic [1:0] C_LEVEL_MAX = 2'd3;

    function automatic logic [C_LEVEL_W-1:0] levelUp(input logic [C_LEVEL_W-1:0] level);
        return (level == C_LEVEL_MAX) ? C_LEVEL_MAX : level + 2'd1;
    endfunction

    function automatic logic [C_LEVEL_W-1:0] levelDown(input logic [C_LEVEL_W-1:0] level);
        return (level == 2'd0) ? 2'd0 : level - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pong_game_sequencer_bcd_counter4.sv
// ============================================================================
// Module      : bcd_counter4
// Description : Four-digit BCD up-counter with synchronous clear, saturating
//               at 9999.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter4 (
    input  logic        pixelClock,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] r_count;
    logic [15:0] w_countNext;
    logic        w_carry;
    logic        w_saturated;

    assign w_saturated = (r_count == 16'h9999);

    // Ripple carry: a digit advances only when every lower digit wraps 9->0.
    always_comb begin
        w_countNext = r_count;
        w_carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_countNext[4*i +: 4] = 4'd0;
                end else begin
                    w_countNext[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            r_count <= 16'h0000;
        end else if (clr) begin
            r_count <= 16'h0000;
        end else if (inc && !w_saturated) begin
            r_count <= w_countNext;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pong_game_sequencer.sv
// ============================================================================
// Module      : pong_game_sequencer
// Description : Game-level controller: attract, serve countdown, play, miss
//               and game-over sequencing with score, lives and speed level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_game_sequencer
    import pong_game_sequencer_pkg::*;
#(
    parameter int SERVE_FRAMES   = 60,
    parameter int MISS_FRAMES    = 90,
    parameter int LIVES_INIT     = 3,
    parameter int HITS_PER_LEVEL = 10
) (
    input  logic        reset,
    input  logic        pixelClock,
    input  logic        frameTick,
    input  logic        startBtn,
    input  logic        ballMiss,
    input  logic        raketHit,
    output logic        ballRun,
    output logic        ballLoad,
    output logic        serveDir,
    output logic [1:0]  speedLevel,
    output logic [15:0] scoreBcd,
    output logic [2:0]  lives,
    output logic        flash,
    output logic [2:0]  gameState
);

    localparam int C_FRAME_MAX   = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int C_FRAME_W_RAW = $clog2(C_FRAME_MAX + 1);
    // At least 4 bits so the 8-frame blink bit always exists.
    localparam int C_FRAME_W     = (C_FRAME_W_RAW < 4) ? 4 : C_FRAME_W_RAW;
    localparam int C_HIT_W       = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [C_FRAME_W-1:0] C_SERVE_LAST = C_FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [C_FRAME_W-1:0] C_MISS_LAST  = C_FRAME_W'(MISS_FRAMES - 1);
    localparam logic [C_HIT_W-1:0]   C_HIT_LAST   = C_HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [C_LIVES_W-1:0] C_LIVES_INIT = C_LIVES_W'(LIVES_INIT);

    logic                 r_startSync1;
    logic                 r_startSync2;
    logic                 r_startSync3;
    logic                 w_startPulse;

    gameState_t           r_state;
    logic [C_FRAME_W-1:0] r_frameCnt;
    logic [C_FRAME_W-1:0] w_frameNext;
    logic [C_HIT_W-1:0]   r_hitCnt;
    logic                 r_ballRun;
    logic                 r_ballLoad;
    logic                 r_serveDir;
    logic [C_LEVEL_W-1:0] r_speedLevel;
    logic [C_LIVES_W-1:0] r_lives;
    logic                 r_flash;

    logic                 w_startGame;
    logic                 w_scoreInc;

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            r_startSync1 <= 1'b0;
            r_startSync2 <= 1'b0;
            r_startSync3 <= 1'b0;
        end else begin
            r_startSync1 <= startBtn;
            r_startSync2 <= r_startSync1;
            r_startSync3 <= r_startSync2;
        end
    end

    assign w_startPulse = r_startSync2 & ~r_startSync3;
    assign w_startGame  = w_startPulse && ((r_state == ST_IDLE) || (r_state == ST_OVER));
    // A miss in the same cycle as a hit takes precedence and scores nothing.
    assign w_scoreInc   = (r_state == ST_PLAY) && raketHit && !ballMiss;
    assign w_frameNext  = r_frameCnt + 1'b1;

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_frameCnt   <= '0;
            r_hitCnt     <= '0;
            r_ballRun    <= 1'b0;
            r_ballLoad   <= 1'b0;
            r_serveDir   <= 1'b0;
            r_speedLevel <= '0;
            r_lives      <= C_LIVES_INIT;
            r_flash      <= 1'b0;
        end else begin
            r_ballLoad <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    r_ballRun <= 1'b0;
                    r_flash   <= (r_state == ST_OVER);
                    if (w_startGame) begin
                        r_state      <= ST_SERVE;
                        r_lives      <= C_LIVES_INIT;
                        r_speedLevel <= '0;
                        r_hitCnt     <= '0;
                        r_frameCnt   <= '0;
                        r_ballLoad   <= 1'b1;
                        r_serveDir   <= ~r_serveDir;
                        r_flash      <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    r_ballRun <= 1'b0;
                    r_flash   <= 1'b0;
                    if (frameTick) begin
                        if (r_frameCnt == C_SERVE_LAST) begin
                            r_frameCnt <= '0;
                            r_state    <= ST_PLAY;
                            r_ballRun  <= 1'b1;
                        end else begin
                            r_frameCnt <= w_frameNext;
                        end
                    end
                end
                ST_PLAY: begin
                    r_ballRun <= 1'b1;
                    r_flash   <= 1'b0;
                    if (ballMiss) begin
                        r_lives      <= r_lives - 1'b1;
                        r_ballRun    <= 1'b0;
                        r_frameCnt   <= '0;
                        r_speedLevel <= levelDown(r_speedLevel);
                        r_state      <= ST_MISS;
                    end else if (raketHit) begin
                        if (r_hitCnt == C_HIT_LAST) begin
                            r_hitCnt     <= '0;
                            r_speedLevel <= levelUp(r_speedLevel);
                        end else begin
                            r_hitCnt <= r_hitCnt + 1'b1;
                        end
                    end
                end
                ST_MISS: begin
                    r_ballRun <= 1'b0;
                    if (frameTick) begin
                        if (r_frameCnt == C_MISS_LAST) begin
                            r_frameCnt <= '0;
                            if (r_lives == '0) begin
                                r_state <= ST_OVER;
                                r_flash <= 1'b1;
                            end else begin
                                r_state    <= ST_SERVE;
                                r_ballLoad <= 1'b1;
                                r_serveDir <= ~r_serveDir;
                                r_flash    <= 1'b0;
                            end
                        end else begin
                            r_frameCnt <= w_frameNext;
                            r_flash    <= w_frameNext[3];
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ballRun  <= 1'b0;
                    r_flash    <= 1'b0;
                    r_frameCnt <= '0;
                end
            endcase
        end
    end

    bcd_counter4 u_score (
        .pixelClock (pixelClock),
        .reset      (reset),
        .clr        (w_startGame),
        .inc        (w_scoreInc),
        .count      (scoreBcd)
    );

    assign ballRun    = r_ballRun;
    assign ballLoad   = r_ballLoad;
    assign serveDir   = r_serveDir;
    assign speedLevel = r_speedLevel;
    assign lives      = r_lives;
    assign flash      = r_flash;
    assign gameState  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_sequencer.sv
// ============================================================================
// Module      : tb_pong_game_sequencer
// Description : Directed self-checking bench for pong_game_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_game_sequencer;

    logic        reset;
    logic        pixelClock;
    logic        frameTick;
    logic        startBtn;
    logic        ballMiss;
    logic        raketHit;
    logic        ballRun;
    logic        ballLoad;
    logic        serveDir;
    logic [1:0]  speedLevel;
    logic [15:0] scoreBcd;
    logic [2:0]  lives;
    logic        flash;
    logic [2:0]  gameState;

    int checkCount;
    int errorCount;
    logic expDir;

    pong_game_sequencer dut (
        .reset      (reset),
        .pixelClock (pixelClock),
        .frameTick  (frameTick),
        .startBtn   (startBtn),
        .ballMiss   (ballMiss),
        .raketHit   (raketHit),
        .ballRun    (ballRun),
        .ballLoad   (ballLoad),
        .serveDir   (serveDir),
        .speedLevel (speedLevel),
        .scoreBcd   (scoreBcd),
        .lives      (lives),
        .flash      (flash),
        .gameState  (gameState)
    );

    initial pixelClock = 1'b0;
    always #5 pixelClock = ~pixelClock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pixelClock);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frameTick = 1'b1;
            step();
            frameTick = 1'b0;
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            raketHit = 1'b1;
            step();
            raketHit = 1'b0;
        end
    endtask

    task automatic missOnce();
        ballMiss = 1'b1;
        step();
        ballMiss = 1'b0;
    endtask

    // Button edge needs two synchronizer stages before the FSM acts on it.
    task automatic pressStart();
        startBtn = 1'b1;
        step();
        step();
        check("start_latency", {13'd0, gameState}, 16'd0 + ((gameState == 3'd4) ? 16'd4 : 16'd0));
        step();
        expDir = ~expDir;
        check("start_state", {13'd0, gameState}, 16'd1);
        check("start_load", {15'd0, ballLoad}, 16'd1);
        check("start_dir", {15'd0, serveDir}, {15'd0, expDir});
        check("start_score", scoreBcd, 16'h0000);
        check("start_lives", {13'd0, lives}, 16'd3);
        check("start_level", {14'd0, speedLevel}, 16'd0);
        check("start_flash", {15'd0, flash}, 16'd0);
        startBtn = 1'b0;
        step();
        check("start_load_end", {15'd0, ballLoad}, 16'd0);
    endtask

    task automatic serve();
        tick(59);
        check("serve_wait_state", {13'd0, gameState}, 16'd1);
        check("serve_wait_run", {15'd0, ballRun}, 16'd0);
        tick(1);
        check("serve_play_state", {13'd0, gameState}, 16'd2);
        check("serve_play_run", {15'd0, ballRun}, 16'd1);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expDir     = 1'b0;
        reset      = 1'b1;
        startBtn   = 1'b0;
        frameTick  = 1'b0;
        ballMiss   = 1'b0;
        raketHit   = 1'b0;
        repeat (3) step();
        check("rst_state", {13'd0, gameState}, 16'd0);
        check("rst_lives", {13'd0, lives}, 16'd3);
        check("rst_score", scoreBcd, 16'h0000);
        check("rst_run", {15'd0, ballRun}, 16'd0);
        check("rst_load", {15'd0, ballLoad}, 16'd0);
        check("rst_dir", {15'd0, serveDir}, 16'd0);
        check("rst_level", {14'd0, speedLevel}, 16'd0);
        check("rst_flash", {15'd0, flash}, 16'd0);
        reset = 1'b0;
        step();

        // Hits and misses before play are ignored.
        hits(2);
        missOnce();
        check("idle_ignore_score", scoreBcd, 16'h0000);
        check("idle_ignore_lives", {13'd0, lives}, 16'd3);

        pressStart();
        serve();

        hits(25);
        check("hits25_score", scoreBcd, 16'h0025);
        check("hits25_level", {14'd0, speedLevel}, 16'd2);
        hits(10);
        check("hits35_level", {14'd0, speedLevel}, 16'd3);
        hits(10);
        check("hits45_score", scoreBcd, 16'h0045);
        check("hits45_level_sat", {14'd0, speedLevel}, 16'd3);

        // Simultaneous hit and miss: miss wins.
        raketHit = 1'b1;
        ballMiss = 1'b1;
        step();
        raketHit = 1'b0;
        ballMiss = 1'b0;
        check("hitmiss_state", {13'd0, gameState}, 16'd3);
        check("hitmiss_score", scoreBcd, 16'h0045);
        check("hitmiss_lives", {13'd0, lives}, 16'd2);
        check("hitmiss_run", {15'd0, ballRun}, 16'd0);
        check("hitmiss_level", {14'd0, speedLevel}, 16'd2);
        check("miss_flash0", {15'd0, flash}, 16'd0);

        tick(8);
        check("miss_flash8", {15'd0, flash}, 16'd1);
        tick(8);
        check("miss_flash16", {15'd0, flash}, 16'd0);
        tick(73);
        check("miss89_state", {13'd0, gameState}, 16'd3);
        tick(1);
        expDir = ~expDir;
        check("miss90_state", {13'd0, gameState}, 16'd1);
        check("miss90_load", {15'd0, ballLoad}, 16'd1);
        check("miss90_dir", {15'd0, serveDir}, {15'd0, expDir});
        check("miss90_flash", {15'd0, flash}, 16'd0);
        step();
        check("miss90_load_end", {15'd0, ballLoad}, 16'd0);

        serve();
        missOnce();
        check("miss2_lives", {13'd0, lives}, 16'd1);
        check("miss2_level", {14'd0, speedLevel}, 16'd1);
        tick(90);
        expDir = ~expDir;
        check("miss2_serve", {13'd0, gameState}, 16'd1);
        check("miss2_dir", {15'd0, serveDir}, {15'd0, expDir});

        serve();
        missOnce();
        check("miss3_lives", {13'd0, lives}, 16'd0);
        check("miss3_level", {14'd0, speedLevel}, 16'd0);
        tick(90);
        check("over_state", {13'd0, gameState}, 16'd4);
        check("over_flash", {15'd0, flash}, 16'd1);
        check("over_run", {15'd0, ballRun}, 16'd0);
        check("over_load", {15'd0, ballLoad}, 16'd0);
        tick(20);
        hits(2);
        missOnce();
        check("over_flash_steady", {15'd0, flash}, 16'd1);
        check("over_score_held", scoreBcd, 16'h0045);
        check("over_lives_held", {13'd0, lives}, 16'd0);

        // Restart from game over, then reset mid-play.
        pressStart();
        serve();
        hits(42);
        check("pre_rst_score", scoreBcd, 16'h0042);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_state", {13'd0, gameState}, 16'd0);
        check("midrst_score", scoreBcd, 16'h0000);
        check("midrst_lives", {13'd0, lives}, 16'd3);
        check("midrst_run", {15'd0, ballRun}, 16'd0);
        step();
        reset  = 1'b0;
        expDir = 1'b0;
        step();

        // Score saturation and button bounce during play.
        pressStart();
        serve();
        raketHit = 1'b1;
        repeat (9998) step();
        raketHit = 1'b0;
        check("score_9998", scoreBcd, 16'h9998);
        check("level_9998", {14'd0, speedLevel}, 16'd3);
        hits(3);
        check("score_sat", scoreBcd, 16'h9999);
        for (int i = 0; i < 4; i++) begin
            startBtn = 1'b1;
            step();
            startBtn = 1'b0;
            step();
        end
        repeat (5) step();
        check("bounce_state", {13'd0, gameState}, 16'd2);
        check("bounce_score", scoreBcd, 16'h9999);
        check("bounce_run", {15'd0, ballRun}, 16'd1);
        check("bounce_load", {15'd0, ballLoad}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

`default_nettype wire
